// File: rtl/upstream_word_arbiter.sv
// Round-robin, burst-limited arbiter that merges NUM_SRC 32-bit word streams into one
// registered PipeOut stream, padding partial host blocks with NOP words after an idle timeout.
module upstream_word_arbiter #(
    parameter int unsigned NUM_SRC     = 3,
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned PAD_TIMEOUT = 64,
    parameter logic [31:0] NOP_WORD    = 32'hBF000001
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_SRC*32-1:0]            src_data,
    input  logic [NUM_SRC-1:0]               src_valid,
    output logic [NUM_SRC-1:0]               src_ready,
    output logic [31:0]                      out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(BLOCK_WORDS)-1:0]   block_pos,
    output logic                             padding
);

    localparam int unsigned PW  = $clog2(NUM_SRC);
    localparam int unsigned PW1 = PW + 1;
    localparam int unsigned BPW = $clog2(BLOCK_WORDS);
    localparam int unsigned BCW = $clog2(BURST_LEN + 1);
    localparam int unsigned IW  = (PAD_TIMEOUT == 0) ? 1 : $clog2(PAD_TIMEOUT + 1);

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]  grant_q, grant_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [BPW-1:0] block_pos_q, block_pos_d;
    logic [31:0]    out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           padding_q, padding_d;
    logic           active_q;

    logic           arb_found;
    logic [PW-1:0]  arb_grant;
    logic [PW1-1:0] idx_w;
    logic [PW-1:0]  cur_grant;
    logic [PW-1:0]  rr_inc;
    logic [31:0]    sel_data;
    logic           load_en;
    logic           hs;
    logic           xfer;
    logic           wrap_xfer;
    logic           any_valid;
    logic           pad_go;
    logic           pad_load;
    logic [BPW-1:0] committed;
    logic [BCW-1:0] burst_inc;

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        arb_found = 1'b0;
        arb_grant = rr_ptr_q;
        idx_w     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx_w = {1'b0, rr_ptr_q} + PW1'(i);
            if (idx_w >= PW1'(NUM_SRC)) begin
                idx_w = idx_w - PW1'(NUM_SRC);
            end
            if (!arb_found && src_valid[idx_w[PW-1:0]]) begin
                arb_found = 1'b1;
                arb_grant = idx_w[PW-1:0];
            end
        end
    end

    assign cur_grant = (state_q == ST_BURST) ? grant_q : arb_grant;
    assign rr_inc    = (cur_grant == PW'(NUM_SRC - 1)) ? '0 : cur_grant + PW'(1);
    assign load_en   = !out_valid_q || out_ready;
    assign xfer      = out_valid_q && out_ready;
    assign wrap_xfer = xfer && (block_pos_q == BPW'(BLOCK_WORDS - 1));
    assign any_valid = |src_valid;
    assign burst_inc = burst_cnt_q + BCW'(1);

    // Words already emitted or waiting in the output register; zero means the block is complete.
    assign committed = block_pos_q + BPW'(out_valid_q);
    assign pad_load  = (state_q == ST_PAD) && load_en && (committed != '0);
    assign pad_go    = (PAD_TIMEOUT != 32'd0) && (idle_cnt_q == IW'(PAD_TIMEOUT))
                       && !any_valid && (block_pos_q != '0);

    always_comb begin
        sel_data  = '0;
        src_ready = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (cur_grant == PW'(k)) begin
                sel_data     = src_data[32*k +: 32];
                src_ready[k] = active_q && load_en && (state_q == ST_ARB || state_q == ST_BURST);
            end
        end
    end

    assign hs = |(src_valid & src_ready);

    // Next-state, counters and output register loading.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        block_pos_d = block_pos_q + BPW'(xfer);
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (load_en) begin
            out_valid_d = hs || pad_load;
            if (hs) begin
                out_data_d = sel_data;
            end else if (pad_load) begin
                out_data_d = NOP_WORD;
            end
        end

        if (hs || (block_pos_q == '0) || (state_q == ST_PAD)) begin
            idle_cnt_d = '0;
        end else if (!any_valid && !out_valid_q && (idle_cnt_q != IW'(PAD_TIMEOUT))) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
        end

        case (state_q)
            ST_ARB: begin
                if (hs) begin
                    grant_d = cur_grant;
                    if (BURST_LEN == 1) begin
                        rr_ptr_d = rr_inc;
                    end else begin
                        burst_cnt_d = BCW'(1);
                        state_d     = ST_BURST;
                    end
                end else if (pad_go) begin
                    state_d = ST_PAD;
                end
            end
            ST_BURST: begin
                if (!src_valid[grant_q]) begin
                    state_d  = ST_ARB;
                    rr_ptr_d = rr_inc;
                end else if (hs) begin
                    if (burst_inc == BCW'(BURST_LEN)) begin
                        state_d  = ST_ARB;
                        rr_ptr_d = rr_inc;
                    end else begin
                        burst_cnt_d = burst_inc;
                    end
                end
            end
            ST_PAD: begin
                if (wrap_xfer) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase

        padding_d = (state_d == ST_PAD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
            block_pos_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            padding_q   <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            block_pos_q <= block_pos_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            padding_q   <= padding_d;
            active_q    <= 1'b1;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign block_pos = block_pos_q;
    assign padding   = padding_q;

endmodule

// File: tb/tb_upstream_word_arbiter.sv
// Bench for upstream_word_arbiter: table of arbitration vectors plus padding, race and reset sequences.
module tb_upstream_word_arbiter;

    localparam int unsigned NSRC = 3;
    localparam int unsigned BL   = 4;
    localparam int unsigned BW   = 4;
    localparam int unsigned PTO  = 8;
    localparam logic [31:0] NOP  = 32'hBF000001;

    logic                 clk;
    logic                 reset_n;
    logic [NSRC*32-1:0]   src_data;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC-1:0]      src_ready;
    logic [31:0]          out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           block_pos;
    logic                 padding;

    upstream_word_arbiter #(
        .NUM_SRC    (NSRC),
        .BURST_LEN  (BL),
        .BLOCK_WORDS(BW),
        .PAD_TIMEOUT(PTO),
        .NOP_WORD   (NOP)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .src_data (src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .block_pos(block_pos),
        .padding  (padding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mask;
        int unsigned nwords;
        logic [31:0] base;
        logic [31:0] stride;
        logic [3:0]  rdy_pat;
        int unsigned exp_total;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] sq0[$], sq1[$], sq2[$], exp_q[$];
    int          n_tests, n_fail, cyc;
    logic [3:0]  rdy_pat;
    int          rdy_idx;
    logic [NSRC-1:0] hs_p;
    logic        xfer_p, xfer_pad, stall_p, last_was_word;
    logic [31:0] xfer_data, stall_data;
    int          last_word_cyc, nop_seen, words_seen, pad_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_src(input int k, input logic [31:0] w);
        case (k)
            0: sq0.push_back(w);
            1: sq1.push_back(w);
            default: sq2.push_back(w);
        endcase
    endtask

    // Scoreboard compare of one observed output transfer.
    task automatic check_out(input logic [31:0] w, input logic pad);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %h want none (cycle %0d)", w, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("out_data", w, e);
            chk("padding_at_xfer", 32'(pad), 32'(e == NOP));
        end
        if (w == NOP) begin
            nop_seen++;
            if (last_was_word) begin
                n_tests++;
                if (cyc - last_word_cyc < int'(PTO) + 1 || cyc - last_word_cyc > int'(PTO) + 4) begin
                    n_fail++;
                    $display("FAIL pad_gap: got %0d want %0d..%0d", cyc - last_word_cyc, PTO + 1, PTO + 4);
                end
            end
            last_was_word = 1'b0;
        end else begin
            words_seen++;
            last_was_word = 1'b1;
            last_word_cyc = cyc;
        end
    endtask

    // One clock: apply the edge just passed, drive new inputs, sample what the next edge will do.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (reset_n) begin
            if (hs_p[0]) void'(sq0.pop_front());
            if (hs_p[1]) void'(sq1.pop_front());
            if (hs_p[2]) void'(sq2.pop_front());
            if (xfer_p) check_out(xfer_data, xfer_pad);
            if (stall_p) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, stall_data);
            end
        end
        out_ready = rdy_pat[rdy_idx];
        rdy_idx   = (rdy_idx + 1) % 4;
        src_valid[0] = (sq0.size() != 0);
        src_valid[1] = (sq1.size() != 0);
        src_valid[2] = (sq2.size() != 0);
        src_data[31:0]  = (sq0.size() != 0) ? sq0[0] : 32'h0;
        src_data[63:32] = (sq1.size() != 0) ? sq1[0] : 32'h0;
        src_data[95:64] = (sq2.size() != 0) ? sq2[0] : 32'h0;
        #1;
        hs_p       = src_valid & src_ready;
        xfer_p     = out_valid && out_ready;
        xfer_data  = out_data;
        xfer_pad   = padding;
        stall_p    = out_valid && !out_ready;
        stall_data = out_data;
        if (reset_n) begin
            n_tests++;
            if (!$onehot0(src_ready)) begin
                n_fail++;
                $display("FAIL ready_onehot: got %b want one-hot or zero", src_ready);
            end
            if (padding) pad_cycles++;
        end
    endtask

    task automatic clear_bench();
        sq0.delete(); sq1.delete(); sq2.delete(); exp_q.delete();
        src_valid = '0;
        hs_p = '0; xfer_p = 1'b0; stall_p = 1'b0;
        last_was_word = 1'b0;
        nop_seen = 0; words_seen = 0; pad_cycles = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_block_pos"}, 32'(block_pos), 32'd0);
        chk({tag, "_padding"}, 32'(padding), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_bench();
        #1;
        check_reset_state("reset");
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_src_ready", 32'(src_ready), 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic run_until_done(input int budget, input string name);
        for (int c = 0; c < budget && (exp_q.size() != 0 || sq0.size() != 0
                                      || sq1.size() != 0 || sq2.size() != 0); c++) begin
            tick();
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_%s: got %0d words pending want 0", name, exp_q.size());
        end
    endtask

    initial begin
        int unsigned rem [3];
        int unsigned ptr, total, k, t;
        logic [31:0] w;

        n_tests = 0; n_fail = 0; cyc = 0; rdy_idx = 0;
        rdy_pat = 4'b1111;
        reset_n = 1'b0;
        out_ready = 1'b0;
        src_data = '0;
        clear_bench();

        vecs[0] = '{mask: 3'b010, nwords: 8,  base: 32'h11,       stride: 32'h0,     rdy_pat: 4'b1111, exp_total: 8};
        vecs[1] = '{mask: 3'b111, nwords: 12, base: 32'hA0000000, stride: 32'h10000, rdy_pat: 4'b1111, exp_total: 36};
        vecs[2] = '{mask: 3'b111, nwords: 12, base: 32'hA0000000, stride: 32'h10000, rdy_pat: 4'b1001, exp_total: 36};
        vecs[3] = '{mask: 3'b101, nwords: 6,  base: 32'hC0000000, stride: 32'h100,   rdy_pat: 4'b1111, exp_total: 12};
        vecs[4] = '{mask: 3'b011, nwords: 2,  base: 32'hD0000000, stride: 32'h100,   rdy_pat: 4'b0101, exp_total: 4};

        // Table vectors: expected order from a round-robin, burst-limited reference.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            rdy_pat = vecs[v].rdy_pat;
            rdy_idx = 0;
            total = 0;
            for (int s = 0; s < 3; s++) begin
                rem[s] = vecs[v].mask[s] ? vecs[v].nwords : 0;
                total += rem[s];
                for (int i = 0; i < int'(rem[s]); i++) begin
                    push_src(s, vecs[v].base + 32'(s) * vecs[v].stride + 32'(i));
                end
            end
            ptr = 0;
            while (total != 0) begin
                k = ptr;
                while (rem[k] == 0) k = (k + 1) % 3;
                t = (rem[k] < BL) ? rem[k] : BL;
                for (int j = 0; j < int'(t); j++) begin
                    w = vecs[v].base + 32'(k) * vecs[v].stride + 32'(vecs[v].nwords - rem[k] + 32'(j));
                    exp_q.push_back(w);
                end
                rem[k] -= t;
                total  -= t;
                ptr = (k + 1) % 3;
            end
            run_until_done(400, "vector");
            repeat (PTO + 4) tick();
            chk("vec_word_count", 32'(words_seen), 32'(vecs[v].exp_total));
            chk("vec_end_block_pos", 32'(block_pos), 32'd0);
            chk("vec_no_padding", 32'(pad_cycles), 32'd0);
        end

        // Padding after idle timeout completes the partial block.
        do_reset();
        rdy_pat = 4'b1111;
        push_src(0, 32'h12345678);
        exp_q.push_back(32'h12345678);
        repeat (3) exp_q.push_back(NOP);
        run_until_done(200, "pad");
        repeat (PTO + 4) tick();
        chk("pad_nop_count", 32'(nop_seen), 32'd3);
        chk("pad_end_block_pos", 32'(block_pos), 32'd0);
        chk("pad_end_padding", 32'(padding), 32'd0);

        // A source arriving as the idle counter hits the timeout wins over padding.
        do_reset();
        push_src(0, 32'h12345678);
        exp_q.push_back(32'h12345678);
        for (int c = 0; c < 50 && words_seen == 0; c++) tick();
        repeat (7) tick();
        push_src(2, 32'hCAFE0001);
        exp_q.push_back(32'hCAFE0001);
        repeat (2) exp_q.push_back(NOP);
        run_until_done(200, "race");
        repeat (PTO + 4) tick();
        chk("race_nop_count", 32'(nop_seen), 32'd2);
        chk("race_end_block_pos", 32'(block_pos), 32'd0);

        // Reset while the second NOP sits in the output register.
        do_reset();
        push_src(0, 32'h12345678);
        exp_q.push_back(32'h12345678);
        repeat (3) exp_q.push_back(NOP);
        for (int c = 0; c < 100 && nop_seen == 0; c++) tick();
        chk("midpad_valid", 32'(out_valid), 32'd1);
        chk("midpad_data", out_data, NOP);
        chk("midpad_block_pos", 32'(block_pos), 32'd2);
        reset_n = 1'b0;
        #1;
        check_reset_state("midpad_reset");
        clear_bench();
        repeat (2) tick();
        reset_n = 1'b1;
        push_src(0, 32'h5A5A0000);
        push_src(1, 32'h5A5A0001);
        exp_q.push_back(32'h5A5A0000);
        exp_q.push_back(32'h5A5A0001);
        repeat (2) exp_q.push_back(NOP);
        run_until_done(200, "post_reset");
        repeat (PTO + 4) tick();
        chk("post_reset_block_pos", 32'(block_pos), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/upstream_word_arbiter.md
Name: upstream_word_arbiter

Overview:
- Shares the single 32-bit upstream PipeOut word stream between NUM_SRC requesters: BD output words, register/channel readback and the heartbeat generator.
- Arbitration is round-robin with a per-grant burst limit.
- When traffic goes idle mid-block, the block pads with NOP words to the host block-pipe size. The host reads only whole blocks, so partial blocks would otherwise stall.
- Sits between the source formatters and the PipeOut FIFO.

Parameters:
NUM_SRC, 3, number of requesting sources (2..8)
BURST_LEN, 4, maximum consecutive words granted to one source before rotation (1..255)
BLOCK_WORDS, 4, host block size in 32-bit words (pipeOutSize/4); must be a power of two, at least 2
PAD_TIMEOUT, 64, idle cycles with a partial block before padding starts; 0 disables padding
NOP_WORD, 32'hBF000001, filler word, decoded as NOP by host software

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
src_data  in  NUM_SRC*32  source words; source k occupies bits [32k+31:32k]
src_valid  in  NUM_SRC  per-source valid
src_ready  out  NUM_SRC  per-source ready; at most one bit high per cycle
out_data  out  32  registered output word
out_valid  out  1  output valid
out_ready  in  1  PipeOut FIFO not full
block_pos  out  log2(BLOCK_WORDS)  words emitted in current block (status)
padding  out  1  high while in PAD state

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream): out_valid=0, out_data=0, src_ready=0, block_pos=0, padding=0, state=ARB, rr_ptr=0, burst_cnt=0, idle_cnt=0.
- Output stage: a single register. It loads when (!out_valid || out_ready).
  - A transfer occurs on out_valid && out_ready.
  - Latency from a source handshake to out_valid is 1 cycle.
  - Full throughput of 1 word/cycle when out_ready is held high.
- src_ready[k] = load_en && (state==ARB || state==BURST) && grant==k. A source handshake is src_valid[k] && src_ready[k]; the word is captured into out_data.
- State ARB:
  - Grant goes to the first valid source searching rr_ptr, rr_ptr+1, … modulo NUM_SRC.
  - On a handshake: burst_cnt=1 and the state moves to BURST holding that grant, unless BURST_LEN==1. In that case rr_ptr=grant+1 and the state stays ARB.
- State BURST:
  - The grant is held while the granted source stays valid. Each handshake increments burst_cnt.
  - Return to ARB with rr_ptr=grant+1 (mod NUM_SRC) when either:
    - burst_cnt reaches BURST_LEN on a handshake, or
    - the granted source deasserts valid.
  - If the granted source is not valid, no word is issued that cycle, giving one bubble.
  - Stalls caused by out_ready=0 do not count toward burst_cnt.
- Block counter: block_pos increments on each output transfer, wrapping to 0 after BLOCK_WORDS-1. Source words and NOP words both count.
- Idle counter:
  - Increments each cycle in ARB/BURST when no src_valid is high, block_pos!=0 and the output register is empty.
  - Clears on any source handshake or when block_pos==0.
  - Saturates at PAD_TIMEOUT.
- PAD entry: when PAD_TIMEOUT!=0 and idle_cnt==PAD_TIMEOUT, go to PAD, with padding=1.
  - If a source becomes valid in the same cycle the counter reaches the timeout, the source wins: the handshake occurs and idle_cnt clears.
- State PAD:
  - src_ready is held at 0.
  - Load NOP_WORD on each load_en until the transfer that wraps block_pos to 0.
  - Then go to ARB with rr_ptr unchanged and idle_cnt=0.
  - Sources arriving during PAD wait.
- No word is ever dropped or duplicated. out_data is stable while out_valid && !out_ready.
- Asserting reset mid-burst or mid-pad returns to the reset state immediately. A word held in the output register is discarded.

Test Plan:
1. Reset and single source: with NUM_SRC=3, source 1 sends 0x00000011..0x00000018 and out_ready=1. Required: the 8 words appear in order with 1-cycle latency, in two bursts of 4 and no idle gap beyond the arbitration cycle. Afterwards block_pos=0 and padding never asserts.
2. Round-robin fairness: all 3 sources continuously valid, each sending 12 words tagged 0xA0000000+k. Required: output order is src0×4, src1×4, src2×4, repeated 3 times. src_ready is one-hot or zero in every cycle.
3. Backpressure: out_ready toggles 1,0,0,1 repeating during scenario 2. Required: the same word sequence as scenario 2, out_data stable through stalls, and no loss or duplication (scoreboard count 36).
4. Padding: BLOCK_WORDS=4, PAD_TIMEOUT=8; source 0 sends a single word 0x12345678, then all sources go idle. Required: 0x12345678 is emitted, then exactly 3 × 0xBF000001 begin after 8 idle cycles, padding=1 for that interval, and block_pos ends at 0.
5. Timeout race: as scenario 4, but source 2 asserts valid with 0xCAFE0001 in the cycle idle_cnt reaches 8. Required: 0xCAFE0001 is emitted with no NOP before it, and idle_cnt restarts.
6. Reset mid-pad: assert reset_n=0 during the second NOP of scenario 4. Required: out_valid=0, block_pos=0 and padding=0 immediately. After release, a new source word is emitted normally from rr_ptr=0.
